// File: rtl/s2mm_capture_ctrl.sv
// Capture sequencer for the S2MM stream filter: runs a programmed number of
// fixed-length frames with idle gaps, watches the m_axis handshake for frame ends and stalls.
module s2mm_capture_ctrl #(
  parameter int LEN_W = 26,
  parameter int CNT_W = 16
) (
  input  logic             axis_aclk,
  input  logic             axis_areset,
  input  logic             start,
  input  logic             abort,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic [CNT_W-1:0] cfg_frames,
  input  logic [CNT_W-1:0] cfg_gap,
  input  logic [CNT_W-1:0] cfg_timeout,
  input  logic             mon_tvalid,
  input  logic             mon_tready,
  input  logic             mon_tlast,
  output logic             filt_en,
  output logic [LEN_W-1:0] filt_counter,
  output logic             busy,
  output logic             done,
  output logic [CNT_W-1:0] frames_done,
  output logic             err_timeout,
  output logic             aborted
);

  // state   | meaning
  // IDLE    | waiting for start
  // ARM     | one cycle with en low so the filter counter is cleared
  // CAPTURE | en high, counting frames and stall cycles
  // GAP     | en low for cfg_gap+1 cycles between frames
  // DONE    | one-cycle done pulse, then back to IDLE
  typedef enum logic [2:0] {
    S_IDLE,
    S_ARM,
    S_CAPTURE,
    S_GAP,
    S_DONE
  } state_t;

  state_t state_q, state_d;

  logic [LEN_W-1:0] len_q, len_d;
  logic [CNT_W-1:0] frames_cfg_q, frames_cfg_d;
  logic [CNT_W-1:0] gap_q, gap_d;
  logic [CNT_W-1:0] timeout_q, timeout_d;
  logic [CNT_W-1:0] frames_done_q, frames_done_d;
  logic [CNT_W-1:0] stall_q, stall_d;
  logic [CNT_W-1:0] gap_cnt_q, gap_cnt_d;
  logic             err_timeout_q, err_timeout_d;
  logic             aborted_q, aborted_d;
  logic             filt_en_q, filt_en_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;

  logic             beat;
  logic             frame_end;
  logic [CNT_W-1:0] frames_inc;

  assign beat       = mon_tvalid & mon_tready;
  assign frame_end  = beat & mon_tlast;
  assign frames_inc = frames_done_q + 1'b1;

  always_comb begin
    state_d       = state_q;
    len_d         = len_q;
    frames_cfg_d  = frames_cfg_q;
    gap_d         = gap_q;
    timeout_d     = timeout_q;
    frames_done_d = frames_done_q;
    stall_d       = stall_q;
    gap_cnt_d     = gap_cnt_q;
    err_timeout_d = err_timeout_q;
    aborted_d     = aborted_q;

    case (state_q)
      S_IDLE: begin
        if (start && !abort) begin
          state_d       = S_ARM;
          len_d         = cfg_len;
          frames_cfg_d  = cfg_frames;
          gap_d         = cfg_gap;
          timeout_d     = cfg_timeout;
          frames_done_d = '0;
          err_timeout_d = 1'b0;
          aborted_d     = 1'b0;
        end
      end

      S_ARM: begin
        if (abort) begin
          state_d   = S_DONE;
          aborted_d = 1'b1;
        end else begin
          state_d = S_CAPTURE;
          stall_d = '0;
        end
      end

      S_CAPTURE: begin
        // a frame end racing an abort is still counted
        if (frame_end) begin
          frames_done_d = frames_inc;
        end
        if (beat) begin
          stall_d = '0;
        end else begin
          stall_d = stall_q + 1'b1;
        end

        if (abort) begin
          state_d   = S_DONE;
          aborted_d = 1'b1;
        end else if (frame_end) begin
          if ((frames_cfg_q != '0) && (frames_inc == frames_cfg_q)) begin
            state_d = S_DONE;
          end else begin
            state_d   = S_GAP;
            gap_cnt_d = gap_q;
          end
        end else if ((timeout_q != '0) && (stall_q == timeout_q)) begin
          state_d       = S_DONE;
          err_timeout_d = 1'b1;
        end
      end

      S_GAP: begin
        if (abort) begin
          state_d   = S_DONE;
          aborted_d = 1'b1;
        end else if (gap_cnt_q == '0) begin
          state_d = S_CAPTURE;
          stall_d = '0;
        end else begin
          gap_cnt_d = gap_cnt_q - 1'b1;
        end
      end

      S_DONE: begin
        state_d = S_IDLE;
      end

      default: begin
        state_d = S_IDLE;
      end
    endcase

    // outputs registered from the next state so they line up with it
    filt_en_d = (state_d == S_CAPTURE);
    busy_d    = (state_d != S_IDLE);
    done_d    = (state_d == S_DONE);
  end

  always_ff @(posedge axis_aclk or posedge axis_areset) begin
    if (axis_areset) begin
      state_q       <= S_IDLE;
      len_q         <= '0;
      frames_cfg_q  <= '0;
      gap_q         <= '0;
      timeout_q     <= '0;
      frames_done_q <= '0;
      stall_q       <= '0;
      gap_cnt_q     <= '0;
      err_timeout_q <= 1'b0;
      aborted_q     <= 1'b0;
      filt_en_q     <= 1'b0;
      busy_q        <= 1'b0;
      done_q        <= 1'b0;
    end else begin
      state_q       <= state_d;
      len_q         <= len_d;
      frames_cfg_q  <= frames_cfg_d;
      gap_q         <= gap_d;
      timeout_q     <= timeout_d;
      frames_done_q <= frames_done_d;
      stall_q       <= stall_d;
      gap_cnt_q     <= gap_cnt_d;
      err_timeout_q <= err_timeout_d;
      aborted_q     <= aborted_d;
      filt_en_q     <= filt_en_d;
      busy_q        <= busy_d;
      done_q        <= done_d;
    end
  end

  assign filt_en      = filt_en_q;
  assign filt_counter = len_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign frames_done  = frames_done_q;
  assign err_timeout  = err_timeout_q;
  assign aborted      = aborted_q;

endmodule
